// File: rtl/noc_output_arbiter.sv
// Output-port stage of the router: round-robin wormhole arbitration across the
// input blocks, a registered link toward the neighbour, and per-VC credit counters.
module noc_output_arbiter #(
  parameter int NUM_INPUTS = 5,
  parameter int FLIT_WIDTH = 64,
  parameter int CHANNELS   = 2,
  parameter int CREDIT_MAX = 4,
  parameter int VC_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           noc_clk,
  input  logic                           noc_rst_n,
  input  logic [NUM_INPUTS-1:0]          req_valid,
  input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] req_flit,
  input  logic [NUM_INPUTS*VC_W-1:0]     req_vc,
  input  logic [NUM_INPUTS-1:0]          req_head,
  input  logic [NUM_INPUTS-1:0]          req_tail,
  output logic [NUM_INPUTS-1:0]          req_ready,
  output logic                           out_valid,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic [VC_W-1:0]                out_vc,
  output logic                           out_tail,
  input  logic                           credit_valid,
  input  logic [VC_W-1:0]                credit_vc,
  output logic                           port_busy,
  output logic [2:0]                     owner,
  output logic                           credit_err
);

  // Handshake: a flit moves on input i in a cycle where req_valid[i] && req_ready[i];
  // req_ready is combinational, so requesters hold valid and payload until accepted.

  localparam int CNT_W    = $clog2(CREDIT_MAX + 1);
  localparam int PTR_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int VC_SLOTS = 1 << VC_W;
  localparam logic [CNT_W-1:0] CRED_FULL = CNT_W'(CREDIT_MAX);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [2:0]            r_owner;
  logic [VC_W-1:0]       r_locked_vc;
  logic [CNT_W-1:0]      r_credit [CHANNELS];
  logic                  r_credit_err;
  logic                  r_out_valid;
  logic [FLIT_WIDTH-1:0] r_out_flit;
  logic [VC_W-1:0]       r_out_vc;
  logic                  r_out_tail;

  logic [FLIT_WIDTH-1:0] w_flit  [NUM_INPUTS];
  logic [VC_W-1:0]       w_in_vc [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] w_cand;
  logic [VC_SLOTS-1:0]   w_vc_ok;
  logic [NUM_INPUTS-1:0] w_ready;
  logic [2:0]            w_sel;
  logic                  w_xfer;
  logic                  w_sel_tail;
  logic [VC_W-1:0]       w_send_vc;
  logic [PTR_W-1:0]      w_rr_next;
  logic [CHANNELS-1:0]   w_dec;
  logic [CHANNELS-1:0]   w_inc;

  // VC indices beyond CHANNELS never have credit, so such heads are never granted.
  for (genvar v = 0; v < VC_SLOTS; v++) begin : g_vc_ok
    if (v < CHANNELS) begin : g_real
      assign w_vc_ok[v] = (r_credit[v] != '0);
    end else begin : g_none
      assign w_vc_ok[v] = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign w_flit[i]  = req_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
    assign w_in_vc[i] = req_vc[i*VC_W +: VC_W];
    assign w_cand[i]  = req_valid[i] & req_head[i] & w_vc_ok[w_in_vc[i]];
  end

  always_comb begin : arb_comb
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    w_ready = '0;
    w_sel   = '0;
    if (r_state == ST_IDLE) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
        if (!found && w_cand[idx]) begin
          found = 1'b1;
          w_sel = 3'(idx);
        end
      end
      if (found) w_ready[w_sel] = 1'b1;
    end else begin
      // Body flits ride the VC captured from the head; req_vc/req_head are ignored.
      w_sel = r_owner;
      if (req_valid[r_owner] && w_vc_ok[r_locked_vc]) w_ready[r_owner] = 1'b1;
    end
  end

  assign w_xfer     = |w_ready;
  assign w_sel_tail = req_tail[w_sel];
  assign w_send_vc  = (r_state == ST_IDLE) ? w_in_vc[w_sel] : r_locked_vc;
  assign w_rr_next  = (int'(w_sel) >= NUM_INPUTS - 1) ? '0 : PTR_W'(w_sel) + 1'b1;

  always_comb begin : credit_comb
    w_dec = '0;
    w_inc = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      w_dec[v] = w_xfer && (w_send_vc == VC_W'(v));
      w_inc[v] = credit_valid && (credit_vc == VC_W'(v));
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin : credit_ff
    if (!noc_rst_n) begin
      for (int v = 0; v < CHANNELS; v++) r_credit[v] <= CRED_FULL;
      r_credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < CHANNELS; v++) begin
        if (w_inc[v] && !w_dec[v]) begin
          // A return into a full counter means the neighbour over-credited us.
          if (r_credit[v] == CRED_FULL) r_credit_err <= 1'b1;
          else                          r_credit[v] <= r_credit[v] + 1'b1;
        end else if (w_dec[v] && !w_inc[v]) begin
          r_credit[v] <= r_credit[v] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin : fsm_ff
    if (!noc_rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_locked_vc <= '0;
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_vc    <= '0;
      r_out_tail  <= 1'b0;
    end else begin
      r_out_valid <= w_xfer;
      r_out_flit  <= w_xfer ? w_flit[w_sel] : '0;
      r_out_vc    <= w_xfer ? w_send_vc : '0;
      r_out_tail  <= w_xfer & w_sel_tail;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_rr_ptr <= w_rr_next;
            // Single-flit packets leave the port open for the next head at once.
            if (!w_sel_tail) begin
              r_state     <= ST_LOCKED;
              r_owner     <= w_sel;
              r_locked_vc <= w_in_vc[w_sel];
            end
          end
        end
        ST_LOCKED: begin
          if (w_xfer && w_sel_tail) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= '0;
        end
      endcase
    end
  end

  assign req_ready  = w_ready;
  assign out_valid  = r_out_valid;
  assign out_flit   = r_out_flit;
  assign out_vc     = r_out_vc;
  assign out_tail   = r_out_tail;
  assign port_busy  = (r_state == ST_LOCKED);
  assign owner      = r_owner;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a packet-level reference model and an expected-output queue.
module tb_noc_output_arbiter;

  localparam int NI   = 5;
  localparam int FW   = 64;
  localparam int CH   = 2;
  localparam int CMAX = 4;
  localparam int VW   = 1;
  localparam int OW   = 2 + VW + FW;

  logic               noc_clk = 1'b0;
  logic               noc_rst_n = 1'b1;
  logic [NI-1:0]      req_valid = '0;
  logic [NI*FW-1:0]   req_flit = '0;
  logic [NI*VW-1:0]   req_vc = '0;
  logic [NI-1:0]      req_head = '0;
  logic [NI-1:0]      req_tail = '0;
  logic [NI-1:0]      req_ready;
  logic               out_valid;
  logic [FW-1:0]      out_flit;
  logic [VW-1:0]      out_vc;
  logic               out_tail;
  logic               credit_valid = 1'b0;
  logic [VW-1:0]      credit_vc = '0;
  logic               port_busy;
  logic [2:0]         owner;
  logic               credit_err;

  noc_output_arbiter #(
    .NUM_INPUTS(NI), .FLIT_WIDTH(FW), .CHANNELS(CH), .CREDIT_MAX(CMAX), .VC_W(VW)
  ) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .req_valid(req_valid), .req_flit(req_flit), .req_vc(req_vc),
    .req_head(req_head), .req_tail(req_tail), .req_ready(req_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc), .out_tail(out_tail),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .port_busy(port_busy), .owner(owner), .credit_err(credit_err)
  );

  // ---------------- clock / reset ----------------
  always #5 noc_clk = ~noc_clk;

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [OW-1:0] exp_q[$];
  int grant_log[$];
  int n_out, n_out_vc1, n_out_tail, n_busy;

  int pkt_len_q[NI][$];
  int pkt_vc_q[NI][$];
  int cur_idx[NI];
  bit offered[NI];
  logic [FW-1:0] d_flit[NI];
  int offer_pct = 100;
  int cr_mode = 0;
  bit force_cr = 0;
  int force_vc = 0;

  // reference model: port-level packet ownership and credit bookkeeping
  bit m_busy;
  int m_owner, m_lvc, m_rr;
  int m_cred[CH];
  bit m_err;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_lvc = 0; m_rr = 0; m_err = 0;
    for (int v = 0; v < CH; v++) m_cred[v] = CMAX;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic gen_clear();
    for (int i = 0; i < NI; i++) begin
      pkt_len_q[i].delete();
      pkt_vc_q[i].delete();
      cur_idx[i] = 0;
      offered[i] = 0;
    end
  endtask

  task automatic load_pkt(input int i, input int len, input int vc);
    pkt_len_q[i].push_back(len);
    pkt_vc_q[i].push_back(vc);
  endtask

  task automatic clear_stats();
    n_out = 0; n_out_vc1 = 0; n_out_tail = 0; n_busy = 0;
    grant_log.delete();
  endtask

  task automatic drive_idle();
    req_valid = '0; req_head = '0; req_tail = '0; req_flit = '0; req_vc = '0;
    credit_valid = 1'b0; credit_vc = '0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    int v;
    for (int i = 0; i < NI; i++) begin
      if (!offered[i] && pkt_len_q[i].size() > 0 && $urandom_range(0, 99) < offer_pct) begin
        offered[i] = 1;
        d_flit[i] = {$urandom, $urandom};
      end
      if (offered[i]) begin
        req_valid[i] = 1'b1;
        req_head[i]  = (cur_idx[i] == 0);
        req_tail[i]  = (cur_idx[i] == pkt_len_q[i][0] - 1);
        req_vc[i*VW +: VW] = VW'(pkt_vc_q[i][0]);
        req_flit[i*FW +: FW] = d_flit[i];
      end else begin
        req_valid[i] = 1'b0;
        req_head[i]  = 1'($urandom);
        req_tail[i]  = 1'($urandom);
        req_vc[i*VW +: VW] = VW'($urandom);
        req_flit[i*FW +: FW] = {$urandom, $urandom};
      end
    end
    credit_valid = 1'b0;
    credit_vc = VW'($urandom);
    if (force_cr) begin
      credit_valid = 1'b1;
      credit_vc = VW'(force_vc);
      force_cr = 0;
    end else if (cr_mode == 1 && $urandom_range(0, 1) == 1) begin
      v = $urandom_range(0, CH - 1);
      if (m_cred[v] < CMAX) begin
        credit_valid = 1'b1;
        credit_vc = VW'(v);
      end
    end
  endtask

  // One cycle: drive, predict, compare, then advance the model and the sources.
  task automatic run_cycle();
    int g, idx, svc, hvc;
    logic [NI-1:0] exp_ready;
    logic [OW-1:0] e;
    bit s, r;
    @(negedge noc_clk);
    drive_inputs();
    #1;
    g = -1;
    if (!m_busy) begin
      for (int k = 0; k < NI; k++) begin
        idx = (m_rr + k) % NI;
        hvc = int'(req_vc[idx*VW +: VW]);
        if (g < 0 && req_valid[idx] && req_head[idx] && m_cred[hvc] > 0) g = idx;
      end
    end else if (req_valid[m_owner] && m_cred[m_lvc] > 0) begin
      g = m_owner;
    end
    exp_ready = (g >= 0) ? NI'(1 << g) : '0;
    check_val("req_ready", req_ready, exp_ready);
    check_val("port_busy", port_busy, m_busy);
    check_val("owner", owner, m_owner);
    check_val("credit_err", credit_err, m_err);
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_val("out_valid", out_valid, e[OW-1]);
      if (e[OW-1]) begin
        check_val("out_tail", out_tail, e[OW-2]);
        check_val("out_vc", out_vc, e[FW +: VW]);
        check_val("out_flit", out_flit, e[FW-1:0]);
      end
    end
    for (int i = 0; i < NI; i++) if (req_ready[i]) grant_log.push_back(i);
    if (out_valid) n_out++;
    if (out_valid && out_vc == 1) n_out_vc1++;
    if (out_valid && out_tail) n_out_tail++;
    if (port_busy) n_busy++;

    svc = -1;
    if (g >= 0) begin
      svc = m_busy ? m_lvc : int'(req_vc[g*VW +: VW]);
      exp_q.push_back({1'b1, req_tail[g], VW'(svc), req_flit[g*FW +: FW]});
    end else begin
      exp_q.push_back('0);
    end
    for (int v = 0; v < CH; v++) begin
      s = (svc == v);
      r = credit_valid && (int'(credit_vc) == v);
      if (r && !s) begin
        if (m_cred[v] == CMAX) m_err = 1;
        else m_cred[v]++;
      end else if (s && !r) begin
        m_cred[v]--;
      end
    end
    if (g >= 0) begin
      if (!m_busy) begin
        m_rr = (g + 1) % NI;
        if (!req_tail[g]) begin
          m_busy = 1; m_owner = g; m_lvc = svc;
        end
      end else if (req_tail[g]) begin
        m_busy = 0; m_owner = 0;
      end
      offered[g] = 0;
      cur_idx[g]++;
      if (cur_idx[g] == pkt_len_q[g][0]) begin
        void'(pkt_len_q[g].pop_front());
        void'(pkt_vc_q[g].pop_front());
        cur_idx[g] = 0;
      end
    end
  endtask

  task automatic run_n(input int n);
    for (int c = 0; c < n; c++) run_cycle();
  endtask

  function automatic bit all_idle();
    bit ok;
    ok = !m_busy;
    for (int i = 0; i < NI; i++) if (pkt_len_q[i].size() != 0) ok = 0;
    for (int v = 0; v < CH; v++) if (m_cred[v] != CMAX) ok = 0;
    return ok;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    offer_pct = 100;
    cr_mode = 1;
    while (!all_idle() && n < 1000) begin
      run_cycle();
      n++;
    end
    check_val("drain_bound", all_idle(), 1);
    run_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    gen_clear();
    clear_stats();
    drive_idle();
    #2 noc_rst_n = 1'b0;
    #2;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_flit", out_flit, 0);
    check_val("rst_out_vc", out_vc, 0);
    check_val("rst_out_tail", out_tail, 0);
    check_val("rst_port_busy", port_busy, 0);
    check_val("rst_owner", owner, 0);
    check_val("rst_credit_err", credit_err, 0);
    check_val("rst_req_ready", req_ready, 0);
    repeat (3) @(negedge noc_clk);
    noc_rst_n = 1'b1;
    model_reset();

    // simultaneous single-flit heads from reset, then pointer order 4 before 0
    cr_mode = 0;
    load_pkt(0, 1, 0); load_pkt(1, 1, 1); load_pkt(3, 1, 1);
    clear_stats();
    run_n(3);
    load_pkt(0, 1, 0); load_pkt(4, 1, 0);
    run_n(3);
    check_val("t2_grant_cnt", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      check_val("t2_g0", grant_log[0], 0);
      check_val("t2_g1", grant_log[1], 1);
      check_val("t2_g2", grant_log[2], 3);
      check_val("t2_g3", grant_log[3], 4);
      check_val("t2_g4", grant_log[4], 0);
    end
    drain();

    // 3-flit packet from input 2 on VC1
    cr_mode = 0;
    load_pkt(2, 3, 1);
    clear_stats();
    run_n(6);
    check_val("t1_vc1_flits", n_out_vc1, 3);
    check_val("t1_tails", n_out_tail, 1);
    check_val("t1_busy_cycles", n_busy, 2);
    drain();

    // credit exhaustion stalls a locked packet; one return releases one flit
    cr_mode = 0;
    load_pkt(4, 6, 0);
    clear_stats();
    run_n(10);
    check_val("t3_stall_flits", n_out, 4);
    force_cr = 1; force_vc = 0;
    clear_stats();
    run_n(3);
    check_val("t3_one_more", n_out, 1);
    drain();

    // another head waits while input 0 holds the port
    cr_mode = 0;
    load_pkt(0, 4, 1);
    clear_stats();
    run_n(1);
    load_pkt(1, 1, 0);
    run_n(6);
    check_val("t4_grant_cnt", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      check_val("t4_g3", grant_log[3], 0);
      check_val("t4_g4", grant_log[4], 1);
    end
    drain();

    // send and return on VC0 in one cycle at credit 2, then over-return at full
    cr_mode = 0;
    load_pkt(2, 1, 0); load_pkt(2, 1, 0);
    run_n(3);
    load_pkt(2, 1, 0);
    force_cr = 1; force_vc = 0;
    run_n(2);
    load_pkt(2, 1, 0); load_pkt(2, 1, 0); load_pkt(2, 1, 0);
    clear_stats();
    run_n(6);
    check_val("t5_cred_two", n_out, 2);
    drain();
    cr_mode = 0;
    force_cr = 1; force_vc = 0;
    run_n(2);
    check_val("t5_err_set", credit_err, 1);
    for (int k = 0; k < 5; k++) load_pkt(3, 1, 0);
    clear_stats();
    run_n(8);
    check_val("t5_cred_sat", n_out, 4);
    drain();

    // random traffic with bursts of withheld credits
    for (int c = 0; c < 400; c++) begin
      int i;
      cr_mode = (c % 100 < 70) ? 1 : 0;
      offer_pct = 70;
      if ($urandom_range(0, 3) == 0) begin
        i = $urandom_range(0, NI - 1);
        if (pkt_len_q[i].size() < 3) load_pkt(i, $urandom_range(1, 5), $urandom_range(0, CH - 1));
      end
      run_cycle();
    end
    drain();

    // reset in the middle of a locked packet with credit[0]=1
    cr_mode = 0;
    load_pkt(0, 8, 0);
    run_n(3);
    @(posedge noc_clk);
    #2 noc_rst_n = 1'b0;
    #1;
    check_val("t6_busy_rst", port_busy, 0);
    check_val("t6_valid_rst", out_valid, 0);
    check_val("t6_owner_rst", owner, 0);
    check_val("t6_err_rst", credit_err, 0);
    check_val("t6_ready_rst", req_ready, 0);
    gen_clear();
    drive_idle();
    @(negedge noc_clk);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    model_reset();
    load_pkt(0, 5, 0);
    clear_stats();
    run_n(8);
    check_val("t6_grants", grant_log.size(), 4);
    if (grant_log.size() > 0) check_val("t6_first", grant_log[0], 0);
    check_val("t6_flits", n_out, 4);
    drain();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL global_timeout observed=%0d expected=0", 1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
